ysyx_25020037_axil_uart_tx: RTL and testbench

- AXI4-Lite responder on a crossbar device port: accepts CPU stores into a TX FIFO and serialises bytes onto a single 8N1 UART line.
- Paired with the LSU initiator through the crossbar, in place of the stub UART device.
- Exposes data, status and baud-divisor registers; reads return status and configuration.

---
 rtl/ysyx_25020037_axil_uart_tx_pkg.sv | 20 ++
 rtl/ysyx_25020037_sync_fifo.sv | 49 ++++
 rtl/ysyx_25020037_axil_uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_25020037_axil_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25020037_axil_uart_tx_pkg.sv
// Shared definitions for the AXI4-Lite UART transmitter: register offsets,
// AXI response codes and serializer state encodings.
package ysyx_25020037_axil_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/ysyx_25020037_sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module ysyx_25020037_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ysyx_25020037_axil_uart_tx.sv
// AXI4-Lite slave that queues CPU stores in a TX FIFO and shifts them out
// as 8N1 frames on tx, with a programmable clocks-per-bit divisor.
module ysyx_25020037_axil_uart_tx
    import ysyx_25020037_axil_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   div, div_next;
    logic          div_we;

    logic          aw_held, w_held;
    logic [1:0]    aw_reg;
    logic [15:0]   w_data;
    logic [1:0]    w_strb;
    logic          aw_fire, w_fire, ar_fire, do_write;
    logic [1:0]    wr_reg;
    logic [15:0]   wr_data;
    logic [1:0]    wr_strb;
    logic [1:0]    wr_resp;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;

    tx_state_t     state, state_next;
    logic [7:0]    shift;
    logic [15:0]   bit_div, bit_cnt;
    logic [2:0]    bit_idx;
    logic          bit_end, busy;

    logic          unused_bits;
    assign unused_bits = ^{araddr[31:4], araddr[1:0], awaddr[31:4], awaddr[1:0],
                           wdata[31:16], wstrb[3:2]};

    ysyx_25020037_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (wr_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Each channel is ready exactly while its holding register is free.
    assign awready  = !aw_held;
    assign wready   = !w_held;
    assign aw_fire  = awvalid && awready;
    assign w_fire   = wvalid && wready;
    assign ar_fire  = arvalid && arready;
    assign wr_reg   = aw_held ? aw_reg : awaddr[3:2];
    assign wr_data  = w_held ? w_data : wdata[15:0];
    assign wr_strb  = w_held ? w_strb : wstrb[1:0];
    assign do_write = (aw_held || aw_fire) && (w_held || w_fire) && !bvalid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_resp   = RESP_OKAY;
        fifo_push = 1'b0;
        div_we    = 1'b0;
        div_next  = div;
        case (wr_reg)
            REG_TXDATA: begin
                if (wr_strb[0]) begin
                    if (fifo_full) wr_resp = RESP_SLVERR;
                    else           fifo_push = do_write;
                end
            end
            REG_DIV: begin
                div_we = 1'b1;
                if (wr_strb[0]) div_next[7:0]  = wr_data[7:0];
                if (wr_strb[1]) div_next[15:8] = wr_data[15:8];
                if (div_next == 16'd0) div_next = 16'd1;
            end
            default: wr_resp = RESP_DECERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_reg  <= 2'd0;
            w_data  <= 16'd0;
            w_strb  <= 2'd0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            div     <= DEFAULT_DIV;
        end else begin
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_reg  <= awaddr[3:2];
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= wdata[15:0];
                w_strb <= wstrb[1:0];
            end
            if (do_write) begin
                bvalid <= 1'b1;
                bresp  <= wr_resp;
                if (div_we) div <= div_next;
            end else if (bvalid && bready) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        case (araddr[3:2])
            REG_TXDATA: rd_data = 32'd0;
            REG_STATUS: rd_data = {16'd0, 8'(fifo_count), 5'd0, busy, fifo_empty, fifo_full};
            REG_DIV:    rd_data = {16'd0, div};
            default:    rd_resp = RESP_DECERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= 32'd0;
            rresp   <= RESP_OKAY;
        end else if (ar_fire) begin
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_data;
            rresp   <= rd_resp;
        end else if (rvalid && rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
        end
    end

    assign bit_end = (bit_cnt == 16'd0);
    assign busy    = (state != TX_IDLE);

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        tx         = 1'b1;
        case (state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (bit_end) state_next = TX_DATA;
            end
            TX_DATA: begin
                tx = shift[0];
                if (bit_end && bit_idx == 3'd7) state_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_next = TX_START;
                    end else begin
                        state_next = TX_IDLE;
                    end
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_next;
    end

    // A frame snapshots div at load time, so DIV writes only affect later frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift   <= 8'd0;
            bit_div <= DEFAULT_DIV;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
        end else if (fifo_pop) begin
            shift   <= fifo_dout;
            bit_div <= div;
            bit_cnt <= div - 16'd1;
            bit_idx <= 3'd0;
        end else if (state != TX_IDLE) begin
            if (bit_end) begin
                bit_cnt <= bit_div - 16'd1;
                if (state == TX_DATA) begin
                    shift   <= shift >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_axil_uart_tx.sv
// Directed bench for the AXI4-Lite UART transmitter: register access,
// frame waveforms, FIFO overflow, write-channel handshake timing and reset.
module tb_ysyx_25020037_axil_uart_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25020037_axil_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd16)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .tx(tx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        bit aw_hs, w_hs, aw_done, w_done;
        n = 0; aw_done = 0; w_done = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            n++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("write_timeout", 64'(n >= 50), 64'd0);
        resp = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        n = 0;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        check("read_timeout", 64'(n >= 50), 64'd0);
        data = rdata; resp = rresp;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Waits for a start bit, then records tx for ncyc cycles (one sample per negedge).
    task automatic capture(input int ncyc, output logic [63:0] obs, output bit ok);
        int n;
        n = 0; obs = '0;
        while (tx !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        ok = (n < 500);
        for (int i = 0; i < ncyc; i++) begin
            obs[i] = tx;
            @(negedge clk);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int div, input int i);
        int b;
        b = i / div;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd_busy;
        logic [1:0]  rs, rs_busy, ws, ws2;
        logic [63:0] obs, exp;
        bit          ok;

        araddr = 0; arvalid = 0; rready = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_wready",  wready,  1);
        check("rst_rvalid",  rvalid,  0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_rdata",   rdata,   0);
        check("rst_resp",    {bresp, rresp}, 0);
        check("rst_tx",      tx,      1);
        rst = 1'b0;

        axi_read(32'h4, rd, rs);
        check("status_reset", rd, 32'h2);
        check("status_rresp", rs, 2'b00);
        axi_read(32'h8, rd, rs);
        check("div_reset", rd, 32'h10);
        axi_read(32'hC, rd, rs);
        check("unmapped_rresp", rs, 2'b11);
        check("unmapped_rdata", rd, 0);
        axi_read(32'h0, rd, rs);
        check("txdata_read", rd, 0);

        axi_write(32'h4, 32'hFF, 4'hF, ws);
        check("status_write_bresp", ws, 2'b11);
        axi_write(32'h8, 32'h0, 4'h3, ws);
        check("div0_bresp", ws, 2'b00);
        axi_read(32'h8, rd, rs);
        check("div0_reads_1", rd, 32'h1);

        // AW first, W three cycles later, B held off for two cycles.
        @(negedge clk);
        awaddr = 32'h8; wdata = 32'h3; wstrb = 4'h3; awvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
        check("hs_awready_low", awready, 0);
        repeat (2) @(negedge clk);
        check("hs_no_bvalid", bvalid, 0);
        check("hs_wready_high", wready, 1);
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("hs_bvalid_after_w", bvalid, 1);
        check("hs_ready_low", {awready, wready}, 2'b00);
        @(negedge clk);
        check("hs_bvalid_hold", bvalid, 1);
        check("hs_awready_hold", awready, 0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("hs_bvalid_clear", bvalid, 0);
        check("hs_ready_back", {awready, wready}, 2'b11);
        axi_read(32'h8, rd, rs);
        check("hs_div_value", rd, 32'h3);

        // Single 0x55 frame at 4 clocks per bit.
        axi_write(32'h8, 32'h4, 4'h3, ws);
        fork
            capture(40, obs, ok);
            axi_write(32'h0, 32'h55, 4'h1, ws2);
            begin
                repeat (20) @(negedge clk);
                axi_read(32'h4, rd_busy, rs_busy);
            end
        join
        for (int i = 0; i < 40; i++) exp[i] = frame_bit(8'h55, 4, i);
        check("f55_start_seen", ok, 1);
        check("f55_wave", obs[39:0], exp[39:0]);
        check("f55_bresp", ws2, 2'b00);
        check("f55_busy", rd_busy[2], 1);
        check("f55_idle_tx", tx, 1);
        axi_read(32'h4, rd, rs);
        check("f55_status_idle", rd, 32'h2);

        // Two frames back to back at 2 clocks per bit.
        axi_write(32'h8, 32'h2, 4'h3, ws);
        fork
            capture(40, obs, ok);
            begin
                axi_write(32'h0, 32'h41, 4'h1, ws);
                axi_write(32'h0, 32'h42, 4'h1, ws2);
            end
        join
        for (int i = 0; i < 40; i++)
            exp[i] = (i < 20) ? frame_bit(8'h41, 2, i) : frame_bit(8'h42, 2, i - 20);
        check("b2b_start_seen", ok, 1);
        check("b2b_wave", obs[39:0], exp[39:0]);

        // Stall the serializer and overflow the FIFO.
        repeat (4) @(negedge clk);
        axi_write(32'h8, 32'hFFFF, 4'h3, ws);
        for (int i = 0; i < DEPTH + 2; i++) begin
            axi_write(32'h0, 32'(i), 4'h1, ws);
            check($sformatf("fill_bresp_%0d", i), ws, (i == DEPTH + 1) ? 2'b10 : 2'b00);
        end
        axi_read(32'h4, rd, rs);
        check("full_status", rd, 32'h805);
        check("full_count", rd[15:8], 8'd8);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        axi_read(32'h4, rd, rs);
        check("rst_clears_fifo", rd, 32'h2);

        // Reset in the middle of the data bits.
        axi_write(32'h8, 32'h4, 4'h3, ws);
        fork
            capture(10, obs, ok);
            axi_write(32'h0, 32'h55, 4'h1, ws2);
        join
        check("mid_start_seen", ok, 1);
        check("mid_tx_before_rst", tx, 0);
        #1 rst = 1'b1;
        #1 check("mid_tx_on_rst", tx, 1);
        @(negedge clk); rst = 1'b0;
        axi_read(32'h4, rd, rs);
        check("mid_status_after", rd, 32'h2);
        check("mid_tx_after", tx, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
